// File: rtl/vga_pattern_gen.sv
`timescale 1ns/1ps
//-----------------------------------------------------------------------------
// vga_pattern_gen
//
// Purpose:
//   Parametrised VGA timing and test-pattern generator. It sits directly
//   behind the pixel-clock divider and drives the VGA DAC / connector pins.
//   Horizontal and vertical counters walk the full raster, including the
//   porches and sync pulses. A colour index steps once every FRAMES_PER_STEP
//   frames. That index is mapped onto one of four patterns (solid, bars,
//   checkerboard, black). Every output is registered, so all outputs show
//   the same raster position one cycle after the counters held it.
//
// Ports:
//   clk          in   1   pixel clock
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   pixel enable; nothing advances while low
//   mode         in   2   pattern select (00 solid, 01 bars, 10 checker,
//                          11 black); takes effect at the next frame boundary
//   h_sync       out  1   horizontal sync, asserted level = SYNC_POL
//   v_sync       out  1   vertical sync, asserted level = SYNC_POL
//   onscreen     out  1   high while the current pixel is in the active area
//   R, G, B      out  CW  colour channels
//   frame_start  out  1   one-cycle pulse on pixel (0,0) of each frame
//   color        out  3   current colour index
//
// Configuration macro:
//   VGA_BORDER_EN  when defined, the outermost ring of active pixels is
//                  driven all-ones on R/G/B in every mode.
//-----------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_POL        = 0,
    parameter int CW              = 1,
    parameter int FRAMES_PER_STEP = 60,
    parameter int BAR_SHIFT       = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic          h_sync,
    output logic          v_sync,
    output logic          onscreen,
    output logic [CW-1:0] R,
    output logic [CW-1:0] G,
    output logic [CW-1:0] B,
    output logic          frame_start,
    output logic [2:0]    color
);

    //-------------------------------------------------------------------------
    // Derived geometry
    //-------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // A one-frame step still needs a (trivially constant) 1-bit counter.
    localparam int FW      = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ONE  = HW'(1'b1);
    localparam logic [VW-1:0] V_ONE  = VW'(1'b1);
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [FW-1:0] F_ONE  = FW'(1'b1);

    // Window bounds are held at 32 bits so the sync end may equal the
    // total (zero back porch) without overflowing the counter width.
    localparam logic [31:0] H_ACT_W   = 32'(H_ACTIVE);
    localparam logic [31:0] H_SS_W    = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SE_W    = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_W   = 32'(V_ACTIVE);
    localparam logic [31:0] V_SS_W    = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SE_W    = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] H_EDGE_W  = 32'(H_ACTIVE - 1);
    localparam logic [31:0] V_EDGE_W  = 32'(V_ACTIVE - 1);

    localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    //-------------------------------------------------------------------------
    // Helper functions
    //-------------------------------------------------------------------------

    // Pattern colour index for one pixel. Index 0 is black, which also
    // serves as the black pattern.
    function automatic logic [2:0] pattern_idx(
        input logic [1:0] pat,
        input logic [2:0] colour,
        input logic [2:0] h_cell,
        input logic [2:0] v_cell
    );
        logic [2:0] idx;
        case (pat)
            2'b00:   idx = colour;
            2'b01:   idx = h_cell + colour;
            2'b10:   idx = (h_cell[0] ^ v_cell[0]) ? colour : ~colour;
            2'b11:   idx = 3'd0;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

    // Replicate one index bit across a full colour channel.
    function automatic logic [CW-1:0] chan(input logic bit_in);
        return {CW{bit_in}};
    endfunction

    //-------------------------------------------------------------------------
    // Registers
    //-------------------------------------------------------------------------
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]    colour_q, colour_d;
    logic [1:0]    mode_q, mode_d;

    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          onscreen_q, onscreen_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] g_q, g_d;
    logic [CW-1:0] b_q, b_d;
    logic          frame_start_q, frame_start_d;
    logic [2:0]    color_out_q, color_out_d;

    //-------------------------------------------------------------------------
    // Decode of the current raster position
    //-------------------------------------------------------------------------
    logic [31:0] h_pos_s;
    logic [31:0] v_pos_s;
    logic        active_s;
    logic        h_sync_win_s;
    logic        v_sync_win_s;
    logic        frame_end_s;
    logic        frame_first_s;
    logic [2:0]  h_cell_s;
    logic [2:0]  v_cell_s;
    logic [2:0]  pix_idx_s;
    logic        border_s;

    assign h_pos_s  = 32'(h_cnt_q);
    assign v_pos_s  = 32'(v_cnt_q);
    // Cell coordinates wrap at 8 cells; only the low 3 bits matter.
    assign h_cell_s = 3'(h_cnt_q >> BAR_SHIFT);
    assign v_cell_s = 3'(v_cnt_q >> BAR_SHIFT);

    // Region, sync window and frame-boundary decode
    always_comb begin
        active_s      = (h_pos_s < H_ACT_W) && (v_pos_s < V_ACT_W);
        h_sync_win_s  = (h_pos_s >= H_SS_W) && (h_pos_s < H_SE_W);
        v_sync_win_s  = (v_pos_s >= V_SS_W) && (v_pos_s < V_SE_W);
        frame_end_s   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        frame_first_s = (h_cnt_q == HW'(1'b0)) && (v_cnt_q == VW'(1'b0));
    end

    // Outer ring of the active area (constant low when the border is off)
    always_comb begin
`ifdef VGA_BORDER_EN
        border_s = active_s &&
                   ((h_pos_s == 32'd0) || (h_pos_s == H_EDGE_W) ||
                    (v_pos_s == 32'd0) || (v_pos_s == V_EDGE_W));
`else
        border_s = 1'b0;
`endif
    end

    // Pattern index for the current pixel; blanked outside the active area
    always_comb begin
        if (active_s) begin
            pix_idx_s = pattern_idx(mode_q, colour_q, h_cell_s, v_cell_s);
        end else begin
            pix_idx_s = 3'd0;
        end
    end

    //-------------------------------------------------------------------------
    // Raster counters, frame counter, colour step and mode latch
    //-------------------------------------------------------------------------

    // Next-state for the raster walk and per-frame bookkeeping
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        colour_d    = colour_q;
        mode_d      = mode_q;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = HW'(1'b0);
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = VW'(1'b0);
                end else begin
                    v_cnt_d = v_cnt_q + V_ONE;
                end
            end else begin
                h_cnt_d = h_cnt_q + H_ONE;
            end

            // Mode and colour only change between frames so a frame is
            // never drawn with a mix of two patterns or colours.
            if (frame_end_s) begin
                mode_d = mode;
                if (frame_cnt_q == F_LAST) begin
                    frame_cnt_d = FW'(1'b0);
                    colour_d    = colour_q + 3'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q + F_ONE;
                end
            end else begin
                mode_d = mode_q;
            end
        end else begin
            h_cnt_d     = h_cnt_q;
            v_cnt_d     = v_cnt_q;
            frame_cnt_d = frame_cnt_q;
            colour_d    = colour_q;
            mode_d      = mode_q;
        end
    end

    // State registers for the raster walk and per-frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= HW'(1'b0);
            v_cnt_q     <= VW'(1'b0);
            frame_cnt_q <= FW'(1'b0);
            colour_q    <= 3'd0;
            mode_q      <= 2'b00;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            colour_q    <= colour_d;
            mode_q      <= mode_d;
        end
    end

    //-------------------------------------------------------------------------
    // Output stage: one register per output, all loaded from the same
    // counter state so every pin refers to the same pixel.
    //-------------------------------------------------------------------------

    // Next values for the registered outputs
    always_comb begin
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        onscreen_d    = onscreen_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        frame_start_d = frame_start_q;
        color_out_d   = color_out_q;
        if (en) begin
            h_sync_d      = h_sync_win_s ? SYNC_ON : ~SYNC_ON;
            v_sync_d      = v_sync_win_s ? SYNC_ON : ~SYNC_ON;
            onscreen_d    = active_s;
            frame_start_d = frame_first_s;
            color_out_d   = colour_q;
            if (border_s) begin
                r_d = {CW{1'b1}};
                g_d = {CW{1'b1}};
                b_d = {CW{1'b1}};
            end else begin
                r_d = chan(pix_idx_s[2]);
                g_d = chan(pix_idx_s[1]);
                b_d = chan(pix_idx_s[0]);
            end
        end else begin
            h_sync_d      = h_sync_q;
            v_sync_d      = v_sync_q;
            onscreen_d    = onscreen_q;
            r_d           = r_q;
            g_d           = g_q;
            b_d           = b_q;
            frame_start_d = frame_start_q;
            color_out_d   = color_out_q;
        end
    end

    // Output registers; syncs reset to their deasserted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync_q      <= ~SYNC_ON;
            v_sync_q      <= ~SYNC_ON;
            onscreen_q    <= 1'b0;
            r_q           <= {CW{1'b0}};
            g_q           <= {CW{1'b0}};
            b_q           <= {CW{1'b0}};
            frame_start_q <= 1'b0;
            color_out_q   <= 3'd0;
        end else begin
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            onscreen_q    <= onscreen_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            frame_start_q <= frame_start_d;
            color_out_q   <= color_out_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign onscreen    = onscreen_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign frame_start = frame_start_q;
    assign color       = color_out_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
`timescale 1ns/1ps
// Directed testbench for vga_pattern_gen with a 16x8 raster
// (8x4 active), 2 frames per colour step, 2-pixel cells, 2-bit channels.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       h_sync, v_sync, onscreen, frame_start;
    logic [1:0] R, G, B;
    logic [2:0] color;
    logic [5:0] rgb_s;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int pos     = 0;   // enabled clock edges since reset release

`ifdef VGA_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    vga_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .CW(2), .FRAMES_PER_STEP(2), .BAR_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .h_sync(h_sync), .v_sync(v_sync), .onscreen(onscreen),
        .R(R), .G(G), .B(B),
        .frame_start(frame_start), .color(color)
    );

    always #5 clk = ~clk;

    assign rgb_s = {R, G, B};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n clock edges, ending on the following falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (en) pos++;
            @(negedge clk);
        end
    endtask

    // Advance until the outputs show pixel (h,v) of frame f after release
    task automatic go(input int f, input int v, input int h);
        int target;
        target = f * 128 + v * 16 + h + 1;
        for (int k = 0; k < 5000 && pos < target; k++) begin
            @(posedge clk);
            if (en) pos++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] hs_exp;
        logic [15:0] hon_exp;
        logic [7:0]  vs_exp;
        logic [7:0]  von_exp;
        logic [5:0]  bar_exp [8];
        logic [5:0]  e;

        hs_exp  = 16'b1110_0011_1111_1111;  // low on pixels 10..12
        hon_exp = 16'b0000_0000_1111_1111;  // active on pixels 0..7
        vs_exp  = 8'b1001_1111;             // low on lines 5..6
        von_exp = 8'b0000_1111;             // active on lines 0..3
        bar_exp = '{6'd0, 6'd0, 6'd3, 6'd3, 6'd12, 6'd12, 6'd15, 6'd15};

        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_hsync", h_sync, 1'b1);
        chk("rst_vsync", v_sync, 1'b1);
        chk("rst_onscreen", onscreen, 1'b0);
        chk("rst_rgb", rgb_s, 6'd0);
        chk("rst_fstart", frame_start, 1'b0);
        chk("rst_color", color, 3'd0);

        rst_n = 1'b1;
        pos   = 0;

        // First cycle after release shows pixel (0,0)
        go(0, 0, 0);
        chk("first_fstart", frame_start, 1'b1);
        chk("first_onscreen", onscreen, 1'b1);
        chk("first_color", color, 3'd0);
        go(0, 0, 1);
        chk("fstart_pulse", frame_start, 1'b0);

        // Horizontal timing across line 0
        for (int h = 0; h < 16; h++) begin
            go(0, 0, h);
            chk($sformatf("hsync_h%0d", h), h_sync, hs_exp[h]);
            chk($sformatf("hon_h%0d", h), onscreen, hon_exp[h]);
        end

        // Vertical timing, sampled mid-line on every line of frame 1
        for (int v = 0; v < 8; v++) begin
            go(1, v, 5);
            chk($sformatf("vsync_v%0d", v), v_sync, vs_exp[v]);
            chk($sformatf("von_v%0d", v), onscreen, von_exp[v]);
        end

        // Colour step every two frames, solid pattern
        go(1, 7, 15);
        chk("color_f1_end", color, 3'd0);
        go(2, 0, 0);
        chk("color_f2", color, 3'd1);
        chk("fstart_f2", frame_start, 1'b1);
        go(2, 1, 3);
        chk("rgb_col1", rgb_s, 6'b000011);
        go(10, 1, 3);
        chk("color_f10", color, 3'd5);
        chk("rgb_col5", rgb_s, 6'b110011);
        go(10, 1, 9);
        chk("rgb_offscreen", rgb_s, 6'd0);
        chk("onscreen_off", onscreen, 1'b0);
        go(14, 0, 0);
        chk("color_f14", color, 3'd7);
        go(16, 0, 0);
        chk("color_wrap", color, 3'd0);
        chk("fstart_f16", frame_start, 1'b1);

        // Bars requested mid-frame: not visible until next frame
        go(16, 1, 4);
        mode = 2'b01;
        go(16, 2, 4);
        chk("mode_latch_hold", rgb_s, 6'd0);
        for (int h = 0; h < 8; h++) begin
            go(17, 1, h);
            e = (BORDER_ON && (h == 0 || h == 7)) ? 6'h3F : bar_exp[h];
            chk($sformatf("bar_h%0d", h), rgb_s, e);
        end

        // Checkerboard
        go(17, 2, 0);
        mode = 2'b10;
        go(18, 1, 1);
        chk("chk_col1", rgb_s, 6'b111100);
        go(20, 0, 0);
        chk("chk_p00", rgb_s, BORDER_ON ? 6'h3F : 6'b110011);
        go(20, 0, 2);
        chk("chk_p20", rgb_s, BORDER_ON ? 6'h3F : 6'b001100);
        go(20, 1, 1);
        chk("chk_p11", rgb_s, 6'b110011);
        go(20, 1, 2);
        chk("chk_p21", rgb_s, 6'b001100);
        go(20, 2, 2);
        chk("chk_p22", rgb_s, 6'b110011);

        // Black (border ring all-ones when enabled)
        go(20, 3, 3);
        mode = 2'b11;
        go(21, 0, 0);
        chk("blk_p00", rgb_s, BORDER_ON ? 6'h3F : 6'd0);
        go(21, 1, 3);
        chk("blk_p31", rgb_s, 6'd0);
        go(21, 2, 4);
        chk("blk_p42", rgb_s, 6'd0);
        go(21, 2, 7);
        chk("blk_p72", rgb_s, BORDER_ON ? 6'h3F : 6'd0);
        go(21, 3, 3);
        chk("blk_p33", rgb_s, BORDER_ON ? 6'h3F : 6'd0);

        // Enable gating: freeze on pixel (0,0) of frame 22
        go(22, 0, 0);
        en = 1'b0;
        chk("frz_fstart0", frame_start, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk($sformatf("frz_fstart%0d", i + 1), frame_start, 1'b1);
            chk($sformatf("frz_color%0d", i + 1), color, 3'd3);
            chk($sformatf("frz_on%0d", i + 1), onscreen, 1'b1);
        end
        en = 1'b1;
        step(1);
        chk("unfrz_fstart", frame_start, 1'b0);
        go(22, 1, 10);
        chk("unfrz_hsync", h_sync, 1'b0);

        // Asynchronous reset mid-line
        go(22, 2, 11);
        chk("pre_rst_hsync", h_sync, 1'b0);
        chk("pre_rst_color", color, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hsync", h_sync, 1'b1);
        chk("arst_vsync", v_sync, 1'b1);
        chk("arst_color", color, 3'd0);
        chk("arst_fstart", frame_start, 1'b0);
        chk("arst_onscreen", onscreen, 1'b0);
        chk("arst_rgb", rgb_s, 6'd0);
        mode = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        pos   = 0;
        go(0, 0, 0);
        chk("rerst_fstart", frame_start, 1'b1);
        chk("rerst_color", color, 3'd0);
        go(0, 1, 4);
        chk("rerst_mode00", rgb_s, 6'd0);
        chk("rerst_onscreen", onscreen, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
